// File: rtl/mul_hash_if.sv
// Stream interface for mul_hash_pipe: input word stream and hashed output stream.
// The slave modport is the hash block's view; master is the producer/consumer side.
interface mul_hash_if #(
    parameter int IN_W      = 8,
    parameter int NUM_TERMS = 4,
    parameter int PROD_W    = 24,
    parameter int HASH_W    = 16
);
    logic [IN_W-1:0]             s_data;
    logic                        s_last;
    logic                        s_valid;
    logic                        s_ready;
    logic [NUM_TERMS*PROD_W-1:0] m_terms;
    logic [HASH_W-1:0]           m_hash;
    logic                        m_last;
    logic                        m_valid;
    logic                        m_ready;

    modport slave (
        input  s_data, s_last, s_valid, m_ready,
        output s_ready, m_terms, m_hash, m_last, m_valid
    );

    modport master (
        output s_data, s_last, s_valid, m_ready,
        input  s_ready, m_terms, m_hash, m_last, m_valid
    );
endinterface

// File: rtl/mul_hash_pipe.sv
// Flow-controlled multiplicative hash: per-chunk partial products of a*KEY plus a
// hash (top bits of a*KEY) folded across multi-beat keys delimited by s_last.
module mul_hash_pipe #(
    parameter int IN_W       = 8,
    parameter int TERM_W     = 16,
    parameter int NUM_TERMS  = 4,
    parameter     KEY        = 64'h0b4e0ef37bc32127,
    parameter int PROD_W     = 24,
    parameter int HASH_W     = 16,
    parameter int MUL_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    mul_hash_if.slave  bus
);
    localparam int KW = NUM_TERMS * TERM_W;
    localparam int FW = IN_W + TERM_W;
    localparam int LS = MUL_STAGES - 1;
    localparam logic [KW-1:0] KEY_L = KW'(KEY);

    if (PROD_W > FW) begin : g_chk_prod
        $error("mul_hash_pipe: PROD_W exceeds IN_W+TERM_W");
    end
    if (HASH_W > KW) begin : g_chk_hash
        $error("mul_hash_pipe: HASH_W exceeds NUM_TERMS*TERM_W");
    end
    if ($bits(KEY) != KW) begin : g_chk_key
        $error("mul_hash_pipe: KEY width differs from NUM_TERMS*TERM_W");
    end
    if (MUL_STAGES < 1) begin : g_chk_stages
        $error("mul_hash_pipe: MUL_STAGES must be at least 1");
    end

    typedef logic [NUM_TERMS-1:0][FW-1:0] prod_t;

    logic                        stall;
    logic                        en;
    logic [IN_W-1:0]             a_q, a_d;
    logic                        in_v_q, in_v_d;
    logic                        in_l_q, in_l_d;
    prod_t                       mul_q [MUL_STAGES];
    prod_t                       mul_d [MUL_STAGES];
    logic [MUL_STAGES-1:0]       mul_v_q, mul_v_d;
    logic [MUL_STAGES-1:0]       mul_l_q, mul_l_d;
    logic [KW-1:0]               psum;
    logic [HASH_W-1:0]           h;
    logic [HASH_W-1:0]           rot;
    logic [HASH_W-1:0]           acc_q, acc_d;
    logic [HASH_W-1:0]           hash_q, hash_d;
    logic [NUM_TERMS*PROD_W-1:0] terms_q, terms_d;
    logic                        last_q, last_d;
    logic                        valid_q, valid_d;

    // One global enable: every stage freezes together while the output is blocked.
    assign stall       = valid_q && !bus.m_ready;
    assign en          = !stall;
    assign bus.s_ready = en;

    assign bus.m_terms = terms_q;
    assign bus.m_hash  = hash_q;
    assign bus.m_last  = last_q;
    assign bus.m_valid = valid_q;

    always_comb begin : input_stage
        a_d    = a_q;
        in_v_d = in_v_q;
        in_l_d = in_l_q;
        if (en) begin
            in_v_d = bus.s_valid;
            if (bus.s_valid) begin
                a_d    = bus.s_data;
                in_l_d = bus.s_last;
            end
        end
    end

    // Products are formed in the first multiplier stage; later stages only delay them.
    always_comb begin : mul_stages
        for (int i = 0; i < MUL_STAGES; i++) begin
            mul_d[i] = mul_q[i];
        end
        mul_v_d = mul_v_q;
        mul_l_d = mul_l_q;
        if (en) begin
            for (int k = 0; k < NUM_TERMS; k++) begin
                mul_d[0][k] = FW'(a_q) * FW'(KEY_L[k*TERM_W +: TERM_W]);
            end
            mul_v_d[0] = in_v_q;
            mul_l_d[0] = in_l_q;
            for (int i = 1; i < MUL_STAGES; i++) begin
                mul_d[i]   = mul_q[i-1];
                mul_v_d[i] = mul_v_q[i-1];
                mul_l_d[i] = mul_l_q[i-1];
            end
        end
    end

    // The hash uses the untruncated products; m_terms carries only their low PROD_W bits.
    always_comb begin : fold_stage
        psum = '0;
        for (int k = 0; k < NUM_TERMS; k++) begin
            psum = psum + (KW'(mul_q[LS][k]) << (k * TERM_W));
        end
        h   = HASH_W'(psum >> (KW - HASH_W));
        rot = (acc_q << 1) | (acc_q >> (HASH_W - 1));

        acc_d   = acc_q;
        hash_d  = hash_q;
        terms_d = terms_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (en) begin
            valid_d = mul_v_q[LS];
            if (mul_v_q[LS]) begin
                hash_d = rot ^ h;
                last_d = mul_l_q[LS];
                acc_d  = mul_l_q[LS] ? '0 : (rot ^ h);
                for (int k = 0; k < NUM_TERMS; k++) begin
                    terms_d[k*PROD_W +: PROD_W] = mul_q[LS][k][PROD_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            in_v_q  <= 1'b0;
            in_l_q  <= 1'b0;
            for (int i = 0; i < MUL_STAGES; i++) begin
                mul_q[i] <= '0;
            end
            mul_v_q <= '0;
            mul_l_q <= '0;
            acc_q   <= '0;
            hash_q  <= '0;
            terms_q <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            in_v_q  <= in_v_d;
            in_l_q  <= in_l_d;
            for (int i = 0; i < MUL_STAGES; i++) begin
                mul_q[i] <= mul_d[i];
            end
            mul_v_q <= mul_v_d;
            mul_l_q <= mul_l_d;
            acc_q   <= acc_d;
            hash_q  <= hash_d;
            terms_q <= terms_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: tb/tb_mul_hash_pipe.sv
// Bench for mul_hash_pipe: default configuration (dut_a) and a 16-bit, 2-term,
// 3-stage configuration (dut_b), checked against an arithmetic reference model.
module tb_mul_hash_pipe;
    localparam logic [127:0] KEY_A = 128'h0b4e0ef37bc32127;
    localparam logic [127:0] KEY_B = 128'h7bc32127;

    typedef struct packed {
        logic [95:0] t;
        logic [15:0] h;
        logic        l;
    } exp_s;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    mul_hash_if #(.IN_W(8),  .NUM_TERMS(4), .PROD_W(24), .HASH_W(16)) ifa ();
    mul_hash_if #(.IN_W(16), .NUM_TERMS(2), .PROD_W(24), .HASH_W(8))  ifb ();

    mul_hash_pipe dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    mul_hash_pipe #(
        .IN_W       (16),
        .TERM_W     (16),
        .NUM_TERMS  (2),
        .KEY        (32'h7bc32127),
        .PROD_W     (24),
        .HASH_W     (8),
        .MUL_STAGES (3)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hash = top hw bits of (a*key) mod 2^kw.
    function automatic logic [15:0] model_h(input logic [127:0] a, input logic [127:0] key,
                                            input int kw, input int hw);
        logic [127:0] p;
        p = (a * key) & ((128'd1 << kw) - 128'd1);
        return 16'(p >> (kw - hw));
    endfunction

    function automatic logic [95:0] model_terms(input logic [127:0] a, input logic [127:0] key,
                                                input int nt, input int tw, input int pw);
        logic [95:0]  t;
        logic [127:0] chunk;
        logic [127:0] full;
        t = '0;
        for (int k = 0; k < nt; k++) begin
            chunk = (key >> (k * tw)) & ((128'd1 << tw) - 128'd1);
            full  = a * chunk;
            t     = t | (96'(full & ((128'd1 << pw) - 128'd1)) << (k * pw));
        end
        return t;
    endfunction

    function automatic logic [15:0] fold(input logic [15:0] acc, input logic [15:0] h, input int hw);
        int unsigned m;
        int unsigned r;
        m = (32'd1 << hw) - 32'd1;
        r = ((32'(acc) << 1) | (32'(acc) >> (hw - 1))) & m;
        return 16'(r ^ 32'(h));
    endfunction

    task automatic send_wait_a(input logic [7:0] d, input logic l, output int lat);
        ifa.s_data = d; ifa.s_last = l; ifa.s_valid = 1'b1;
        @(negedge clk); #1;
        ifa.s_valid = 1'b0;
        lat = 1;
        while (!ifa.m_valid && lat < 30) begin
            @(negedge clk); #1;
            lat++;
        end
    endtask

    task automatic send_wait_b(input logic [15:0] d, input logic l, output int lat);
        ifb.s_data = d; ifb.s_last = l; ifb.s_valid = 1'b1;
        @(negedge clk); #1;
        ifb.s_valid = 1'b0;
        lat = 1;
        while (!ifb.m_valid && lat < 30) begin
            @(negedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        ifa.m_ready = 1'b0;
        #1;
        checks++;
        if ({ifa.m_valid, ifa.m_last, ifa.m_hash, ifa.m_terms} !== '0)
            begin failures++; $display("FAIL reset_outputs_a got v=%0b l=%0b h=%h t=%h want all 0", ifa.m_valid, ifa.m_last, ifa.m_hash, ifa.m_terms); end
        checks++;
        if (ifa.s_ready !== 1'b1)
            begin failures++; $display("FAIL reset_s_ready got %0b want 1", ifa.s_ready); end
        checks++;
        if ({ifb.m_valid, ifb.m_last, ifb.m_hash, ifb.m_terms} !== '0)
            begin failures++; $display("FAIL reset_outputs_b got v=%0b h=%h want all 0", ifb.m_valid, ifb.m_hash); end
        @(negedge clk);
        rst = 1'b0;
        ifa.m_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (ifa.m_valid !== 1'b0 || ifa.s_ready !== 1'b1)
            begin failures++; $display("FAIL post_reset_idle got v=%0b rdy=%0b want 0/1", ifa.m_valid, ifa.s_ready); end
    endtask

    task automatic test_single_beat();
        int lat;
        send_wait_a(8'h01, 1'b1, lat);
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL latency_a got %0d want 4", lat); end
        checks++;
        if (ifa.m_terms !== {24'h000b4e, 24'h000ef3, 24'h007bc3, 24'h002127})
            begin failures++; $display("FAIL terms_01 got %h want 000b4e000ef3007bc3002127", ifa.m_terms); end
        checks++;
        if (ifa.m_hash !== 16'h0b4e || ifa.m_last !== 1'b1)
            begin failures++; $display("FAIL hash_01 got %h/%0b want 0b4e/1", ifa.m_hash, ifa.m_last); end
        @(negedge clk);
        send_wait_a(8'hff, 1'b1, lat);
        checks++;
        if (ifa.m_terms[23:0] !== 24'h2105d9 || ifa.m_terms[95:72] !== 24'h0b42b2)
            begin failures++; $display("FAIL terms_ff got t0=%h t3=%h want 2105d9/0b42b2", ifa.m_terms[23:0], ifa.m_terms[95:72]); end
        checks++;
        if (ifa.m_hash !== 16'h42c0 || ifa.m_terms !== model_terms(128'hff, KEY_A, 4, 16, 24))
            begin failures++; $display("FAIL hash_ff got %h want 42c0", ifa.m_hash); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat;
        ifa.s_data = 8'h01; ifa.s_last = 1'b0; ifa.s_valid = 1'b1;
        @(negedge clk);
        ifa.s_data = 8'h02; ifa.s_last = 1'b1;
        @(negedge clk); #1;
        ifa.s_valid = 1'b0;
        lat = 2;
        while (!ifa.m_valid && lat < 30) begin @(negedge clk); #1; lat++; end
        checks++;
        if (ifa.m_valid !== 1'b1 || ifa.m_hash !== 16'h0b4e || ifa.m_last !== 1'b0)
            begin failures++; $display("FAIL b2b_beat1 got v=%0b h=%h l=%0b want 1/0b4e/0", ifa.m_valid, ifa.m_hash, ifa.m_last); end
        @(negedge clk); #1;
        checks++;
        if (ifa.m_valid !== 1'b1 || ifa.m_hash !== 16'h0000 || ifa.m_last !== 1'b1)
            begin failures++; $display("FAIL b2b_beat2 got v=%0b h=%h l=%0b want 1/0000/1", ifa.m_valid, ifa.m_hash, ifa.m_last); end
        @(negedge clk);
        send_wait_a(8'h01, 1'b1, lat);
        checks++;
        if (ifa.m_hash !== 16'h0b4e)
            begin failures++; $display("FAIL b2b_restart got %h want 0b4e", ifa.m_hash); end
        @(negedge clk);
    endtask

    task automatic test_stream();
        exp_s        q[$];
        exp_s        e;
        logic [15:0] acc;
        logic [15:0] hh;
        logic        pend;
        logic        stall_prev;
        exp_s        sv;
        int          sent, recv, cyc;
        const int    N = 40;
        acc = '0; pend = 1'b0; stall_prev = 1'b0; sent = 0; recv = 0; cyc = 0; sv = '0;
        while ((sent < N || recv < N) && cyc < 3000) begin
            if (!pend) begin
                if (sent < N && $urandom_range(0, 3) != 0) begin
                    ifa.s_valid = 1'b1;
                    ifa.s_data  = 8'($urandom);
                    ifa.s_last  = ($urandom_range(0, 2) == 0) || (sent == N - 1);
                end else begin
                    ifa.s_valid = 1'b0;
                end
            end
            ifa.m_ready = ($urandom_range(0, 2) != 0);
            #1;
            checks++;
            if (ifa.s_ready !== !(ifa.m_valid && !ifa.m_ready))
                begin failures++; $display("FAIL s_ready_rule cyc=%0d got %0b mv=%0b mr=%0b", cyc, ifa.s_ready, ifa.m_valid, ifa.m_ready); end
            if (stall_prev) begin
                checks++;
                if (ifa.m_valid !== 1'b1 || {ifa.m_terms, ifa.m_hash, ifa.m_last} !== {sv.t, sv.h, sv.l})
                    begin failures++; $display("FAIL stall_stable cyc=%0d got h=%h want h=%h", cyc, ifa.m_hash, sv.h); end
            end
            if (ifa.m_valid && ifa.m_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL stream_extra cyc=%0d got h=%h want no beat", cyc, ifa.m_hash);
                end else begin
                    e = q.pop_front();
                    if ({ifa.m_terms, ifa.m_hash, ifa.m_last} !== {e.t, e.h, e.l})
                        begin failures++; $display("FAIL stream_beat%0d got t=%h h=%h l=%0b want t=%h h=%h l=%0b", recv, ifa.m_terms, ifa.m_hash, ifa.m_last, e.t, e.h, e.l); end
                end
                recv++;
            end
            stall_prev = ifa.m_valid && !ifa.m_ready;
            sv = '{t: ifa.m_terms, h: ifa.m_hash, l: ifa.m_last};
            if (ifa.s_valid && ifa.s_ready) begin
                hh  = model_h(128'(ifa.s_data), KEY_A, 64, 16);
                e.t = model_terms(128'(ifa.s_data), KEY_A, 4, 16, 24);
                e.h = fold(acc, hh, 16);
                e.l = ifa.s_last;
                acc = ifa.s_last ? 16'h0 : e.h;
                q.push_back(e);
                sent++;
                pend = 1'b0;
            end else begin
                pend = ifa.s_valid;
            end
            @(negedge clk);
            cyc++;
        end
        ifa.s_valid = 1'b0;
        ifa.m_ready = 1'b1;
        checks++;
        if (recv != N || q.size() != 0)
            begin failures++; $display("FAIL stream_count got recv=%0d left=%0d want %0d/0", recv, q.size(), N); end
    endtask

    task automatic test_reset_mid_key();
        int          nout;
        int          lat;
        logic [15:0] got_h;
        logic        got_l;
        logic [7:0]  pre [3];
        pre[0] = 8'h5a; pre[1] = 8'h33; pre[2] = 8'hc1;
        // Reset while the partial key is still inside the pipe.
        for (int i = 0; i < 3; i++) begin
            ifa.s_data = 8'($urandom); ifa.s_last = 1'b0; ifa.s_valid = 1'b1;
            @(negedge clk);
        end
        ifa.s_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (ifa.m_valid !== 1'b0 || ifa.s_ready !== 1'b1)
            begin failures++; $display("FAIL midkey_reset got v=%0b rdy=%0b want 0/1", ifa.m_valid, ifa.s_ready); end
        @(negedge clk);
        rst = 1'b0;
        ifa.s_data = 8'h01; ifa.s_last = 1'b1; ifa.s_valid = 1'b1;
        @(negedge clk); #1;
        ifa.s_valid = 1'b0;
        nout = 0; got_h = '0; got_l = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (ifa.m_valid) begin nout++; got_h = ifa.m_hash; got_l = ifa.m_last; end
            @(negedge clk); #1;
        end
        checks++;
        if (nout !== 1 || got_h !== 16'h0b4e || got_l !== 1'b1)
            begin failures++; $display("FAIL midkey_abort got n=%0d h=%h l=%0b want 1/0b4e/1", nout, got_h, got_l); end
        // Reset after partial-key beats have already reached the accumulator.
        for (int i = 0; i < 3; i++) begin
            ifa.s_data = pre[i]; ifa.s_last = 1'b0; ifa.s_valid = 1'b1;
            @(negedge clk);
        end
        ifa.s_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_wait_a(8'h01, 1'b1, lat);
        checks++;
        if (ifa.m_hash !== 16'h0b4e || lat !== 4)
            begin failures++; $display("FAIL acc_reset got h=%h lat=%0d want 0b4e/4", ifa.m_hash, lat); end
        @(negedge clk);
    endtask

    task automatic test_alt_config();
        int          lat;
        logic [15:0] acc;
        logic [15:0] eh;
        logic [15:0] d;
        logic        l;
        send_wait_b(16'h0001, 1'b1, lat);
        checks++;
        if (lat !== 5) begin failures++; $display("FAIL latency_b got %0d want 5", lat); end
        checks++;
        if (ifb.m_terms !== {24'h007bc3, 24'h002127} || ifb.m_hash !== 8'h7b || ifb.m_last !== 1'b1)
            begin failures++; $display("FAIL alt_single got t=%h h=%h want 007bc3002127/7b", ifb.m_terms, ifb.m_hash); end
        @(negedge clk);
        ifb.s_data = 16'h0001; ifb.s_last = 1'b0; ifb.s_valid = 1'b1;
        @(negedge clk);
        ifb.s_data = 16'h0002; ifb.s_last = 1'b1;
        @(negedge clk); #1;
        ifb.s_valid = 1'b0;
        lat = 2;
        while (!ifb.m_valid && lat < 30) begin @(negedge clk); #1; lat++; end
        checks++;
        if (ifb.m_hash !== 8'h7b || ifb.m_last !== 1'b0)
            begin failures++; $display("FAIL alt_b2b_beat1 got h=%h l=%0b want 7b/0", ifb.m_hash, ifb.m_last); end
        @(negedge clk); #1;
        checks++;
        if (ifb.m_valid !== 1'b1 || ifb.m_hash !== 8'h01 || ifb.m_last !== 1'b1)
            begin failures++; $display("FAIL alt_b2b_beat2 got v=%0b h=%h l=%0b want 1/01/1", ifb.m_valid, ifb.m_hash, ifb.m_last); end
        @(negedge clk);
        // Random 6-beat key, one beat at a time, against the model.
        acc = '0;
        for (int i = 0; i < 6; i++) begin
            d  = 16'($urandom);
            l  = (i == 5);
            eh = fold(acc, model_h(128'(d), KEY_B, 32, 8), 8);
            acc = l ? 16'h0 : eh;
            send_wait_b(d, l, lat);
            checks++;
            if (16'(ifb.m_hash) !== eh || ifb.m_last !== l || 96'(ifb.m_terms) !== model_terms(128'(d), KEY_B, 2, 16, 24))
                begin failures++; $display("FAIL alt_rand%0d got h=%h t=%h want h=%h", i, ifb.m_hash, ifb.m_terms, eh); end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        ifa.s_valid = 1'b0; ifa.s_data = '0; ifa.s_last = 1'b0; ifa.m_ready = 1'b1;
        ifb.s_valid = 1'b0; ifb.s_data = '0; ifb.s_last = 1'b0; ifb.m_ready = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_stream();
        test_reset_mid_key();
        test_alt_config();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
